// File: rtl/alu_seq_unit.sv
// alu_seq_unit: handshaked ALU with 1-cycle logic/add/shift ops and
// iterative WIDTH-step MULT/MULTU (and DIV/DIVU when ALU_DIV_EN is defined).
// Ports: clock, reset (sync, active-high); in_valid/in_ready, op, rs, rt,
// shamt request side; out_valid/out_ready, result, hi, lo, zero, overflow,
// illegal response side. Define ALU_DIV_EN to build the restoring divider.
module alu_seq_unit #(
    parameter  int WIDTH = 32,
    localparam int SHW   = $clog2(WIDTH)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] rs,
    input  logic [WIDTH-1:0] rt,
    input  logic [SHW-1:0]   shamt,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             zero,
    output logic             overflow,
    output logic             illegal
);

    localparam logic [3:0] OP_ADD   = 4'b0001;
    localparam logic [3:0] OP_SUB   = 4'b0010;
    localparam logic [3:0] OP_AND   = 4'b0011;
    localparam logic [3:0] OP_OR    = 4'b0100;
    localparam logic [3:0] OP_NOR   = 4'b0101;
    localparam logic [3:0] OP_SLT   = 4'b0110;
    localparam logic [3:0] OP_SLL   = 4'b0111;
    localparam logic [3:0] OP_SRL   = 4'b1000;
    localparam logic [3:0] OP_SRA   = 4'b1001;
    localparam logic [3:0] OP_ADDU  = 4'b1010;
    localparam logic [3:0] OP_SUBU  = 4'b1011;
    localparam logic [3:0] OP_MULT  = 4'b1100;
    localparam logic [3:0] OP_MULTU = 4'b1101;
    localparam logic [3:0] OP_DIV   = 4'b1110;
    localparam logic [3:0] OP_DIVU  = 4'b1111;

    localparam logic [SHW-1:0] LAST = SHW'(WIDTH - 1);

    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_DONE} state_t;

    state_t state, state_nx;

    logic               accept;
    logic               is_iter;
    logic               sgn_op;
    logic               last;
    logic [SHW-1:0]     cnt;
    logic [2*WIDTH-1:0] p;
    logic [2*WIDTH-1:0] p_step;
    logic [2*WIDTH-1:0] mstep;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH:0]     madd;
    logic [WIDTH-1:0]   d;
    logic [WIDTH-1:0]   ma;
    logic [WIDTH-1:0]   mb;
    logic               neg_q;
    logic [WIDTH-1:0]   fin_hi;
    logic [WIDTH-1:0]   fin_lo;
    logic [WIDTH-1:0]   sum;
    logic [WIDTH-1:0]   dif;
    logic [WIDTH-1:0]   sc_res;
    logic               sc_ovf;
    logic               sc_ill;

    assign accept = in_valid & in_ready;
    assign last   = (cnt == LAST);
    assign sgn_op = (op == OP_MULT) || (op == OP_DIV);

`ifdef ALU_DIV_EN
    assign is_iter = (op[3:2] == 2'b11);
`else
    assign is_iter = (op == OP_MULT) || (op == OP_MULTU);
`endif

    // Signed ops iterate on magnitudes; sign is restored after the last step.
    assign ma = (sgn_op && rs[WIDTH-1]) ? -rs : rs;
    assign mb = (sgn_op && rt[WIDTH-1]) ? -rt : rt;

    assign sum = rs + rt;
    assign dif = rs - rt;

    always_comb begin
        sc_res = '0;
        sc_ovf = 1'b0;
        sc_ill = 1'b0;
        unique case (op)
            OP_ADD: begin
                sc_res = sum;
                sc_ovf = (rs[WIDTH-1] == rt[WIDTH-1]) &&
                         (sum[WIDTH-1] != rs[WIDTH-1]);
            end
            OP_SUB: begin
                sc_res = dif;
                sc_ovf = (rs[WIDTH-1] != rt[WIDTH-1]) &&
                         (dif[WIDTH-1] != rs[WIDTH-1]);
            end
            OP_ADDU: sc_res = sum;
            OP_SUBU: sc_res = dif;
            OP_AND:  sc_res = rs & rt;
            OP_OR:   sc_res = rs | rt;
            OP_NOR:  sc_res = ~(rs | rt);
            OP_SLT:  sc_res = {{(WIDTH-1){1'b0}}, $signed(rs) < $signed(rt)};
            OP_SLL:  sc_res = rt << shamt;
            OP_SRL:  sc_res = rt >> shamt;
            OP_SRA:  sc_res = $signed(rt) >>> shamt;
`ifndef ALU_DIV_EN
            OP_DIV, OP_DIVU: sc_ill = 1'b1;
`endif
            default: sc_res = '0;
        endcase
    end

    // Shift-add: low half holds the multiplier, high half accumulates.
    assign madd  = {1'b0, p[2*WIDTH-1:WIDTH]} + (p[0] ? {1'b0, d} : '0);
    assign mstep = {madd, p[WIDTH-1:1]};
    assign prod  = neg_q ? -mstep : mstep;

`ifdef ALU_DIV_EN
    logic               div_q;
    logic               dz_q;
    logic               rneg_q;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH:0]     rsh;
    logic               ge;
    logic [WIDTH-1:0]   rnew;
    logic [2*WIDTH-1:0] dstep;
    logic [WIDTH-1:0]   qm;
    logic [WIDTH-1:0]   rm;

    // Restoring divide: high half is the partial remainder, low half
    // shifts the dividend out and the quotient bits in.
    assign rsh   = {p[2*WIDTH-1:WIDTH], p[WIDTH-1]};
    assign ge    = (rsh >= {1'b0, d});
    assign rnew  = ge ? (rsh[WIDTH-1:0] - d) : rsh[WIDTH-1:0];
    assign dstep = {rnew, p[WIDTH-2:0], ge};
    assign qm    = dstep[WIDTH-1:0];
    assign rm    = dstep[2*WIDTH-1:WIDTH];

    assign p_step = div_q ? dstep : mstep;

    always_comb begin
        fin_hi = prod[2*WIDTH-1:WIDTH];
        fin_lo = prod[WIDTH-1:0];
        if (div_q) begin
            fin_lo = dz_q ? '1  : (neg_q  ? -qm : qm);
            fin_hi = dz_q ? a_q : (rneg_q ? -rm : rm);
        end
    end
`else
    assign p_step = mstep;
    assign fin_hi = prod[2*WIDTH-1:WIDTH];
    assign fin_lo = prod[WIDTH-1:0];
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE: if (in_valid) state_nx = is_iter ? S_EXEC : S_DONE;
            S_EXEC: if (last) state_nx = S_DONE;
            S_DONE: if (out_ready) state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == S_IDLE);
        out_valid = (state == S_DONE);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            result   <= '0;
            hi       <= '0;
            lo       <= '0;
            zero     <= 1'b0;
            overflow <= 1'b0;
            illegal  <= 1'b0;
            p        <= '0;
            d        <= '0;
            cnt      <= '0;
            neg_q    <= 1'b0;
`ifdef ALU_DIV_EN
            div_q    <= 1'b0;
            dz_q     <= 1'b0;
            rneg_q   <= 1'b0;
            a_q      <= '0;
`endif
        end else if (accept) begin
            if (is_iter) begin
                cnt   <= '0;
                neg_q <= sgn_op & (rs[WIDTH-1] ^ rt[WIDTH-1]);
                p     <= {{WIDTH{1'b0}}, mb};
                d     <= ma;
`ifdef ALU_DIV_EN
                div_q  <= op[1];
                dz_q   <= (rt == '0);
                rneg_q <= sgn_op & rs[WIDTH-1];
                a_q    <= rs;
                if (op[1]) begin
                    p <= {{WIDTH{1'b0}}, ma};
                    d <= mb;
                end
`endif
            end else begin
                result   <= sc_res;
                zero     <= (sc_res == '0);
                overflow <= sc_ovf;
                illegal  <= sc_ill;
            end
        end else if (state == S_EXEC) begin
            p   <= p_step;
            cnt <= cnt + SHW'(1);
            if (last) begin
                hi       <= fin_hi;
                lo       <= fin_lo;
                result   <= fin_lo;
                zero     <= (fin_lo == '0);
                overflow <= 1'b0;
                illegal  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_alu_seq_unit.sv
// tb_alu_seq_unit: vector table, hand-written multi-cycle sequences and
// randomized ops against an arithmetic reference model of alu_seq_unit.
module tb_alu_seq_unit;

    localparam longint SMAX = 64'sd2147483647;
    localparam longint SMIN = -64'sd2147483648;

    logic        clock;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  op;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [4:0]  shamt;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        zero;
    logic        overflow;
    logic        illegal;

    int checks = 0;
    int errors = 0;

    logic [31:0] m_hi;
    logic [31:0] m_lo;

    typedef struct {
        logic [31:0] r;
        logic [31:0] h;
        logic [31:0] l;
        logic        z;
        logic        v;
        logic        il;
        int          lat;
    } res_t;

    typedef struct {
        logic [3:0]  o;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  s;
        logic [31:0] r;
        logic        v;
        logic        z;
        logic        il;
        int          lat;
        logic        hl;
        logic [31:0] h;
        logic [31:0] l;
    } vec_t;

    vec_t tbl[$];

    alu_seq_unit #(.WIDTH(32)) dut (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .rs        (rs),
        .rt        (rt),
        .shamt     (shamt),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .hi        (hi),
        .lo        (lo),
        .zero      (zero),
        .overflow  (overflow),
        .illegal   (illegal)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string nm, input logic [63:0] act,
                         input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", nm, act, expv);
        end
    endtask

    // Reference model: plain 64-bit arithmetic on the architectural rules.
    function automatic res_t model(input logic [3:0] o, input logic [31:0] a,
                                   input logic [31:0] b, input logic [4:0] s);
        res_t        e;
        longint      sa;
        longint      sb;
        longint      t;
        logic [63:0] pr;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        e.r = 32'd0;
        e.v = 1'b0;
        e.il = 1'b0;
        e.lat = 1;
        case (o)
            4'h1: begin
                t = sa + sb;
                e.r = a + b;
                e.v = (t > SMAX) || (t < SMIN);
            end
            4'h2: begin
                t = sa - sb;
                e.r = a - b;
                e.v = (t > SMAX) || (t < SMIN);
            end
            4'hA: e.r = a + b;
            4'hB: e.r = a - b;
            4'h3: e.r = a & b;
            4'h4: e.r = a | b;
            4'h5: e.r = ~(a | b);
            4'h6: e.r = (sa < sb) ? 32'd1 : 32'd0;
            4'h7: e.r = b << s;
            4'h8: e.r = b >> s;
            4'h9: e.r = $signed(b) >>> s;
            4'hC: begin
                pr = sa * sb;
                m_hi = pr[63:32];
                m_lo = pr[31:0];
                e.r = m_lo;
                e.lat = 33;
            end
            4'hD: begin
                pr = {32'd0, a} * {32'd0, b};
                m_hi = pr[63:32];
                m_lo = pr[31:0];
                e.r = m_lo;
                e.lat = 33;
            end
            4'hE, 4'hF: begin
`ifdef ALU_DIV_EN
                if (b == 32'd0) begin
                    m_lo = 32'hFFFFFFFF;
                    m_hi = a;
                end else if (o == 4'hE) begin
                    pr = sa / sb;
                    m_lo = pr[31:0];
                    pr = sa % sb;
                    m_hi = pr[31:0];
                end else begin
                    m_lo = a / b;
                    m_hi = a % b;
                end
                e.r = m_lo;
                e.lat = 33;
`else
                e.il = 1'b1;
`endif
            end
            default: e.r = 32'd0;
        endcase
        e.z = (e.r == 32'd0);
        e.h = m_hi;
        e.l = m_lo;
        return e;
    endfunction

    task automatic apply(input logic [3:0] o, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] s,
                         output res_t act);
        int busy;
        @(negedge clock);
        check("idle_ready", in_ready, 1);
        in_valid = 1'b1;
        op = o;
        rs = a;
        rt = b;
        shamt = s;
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        op = 4'($urandom);
        rs = $urandom;
        rt = $urandom;
        shamt = 5'($urandom);
        act.lat = 0;
        busy = 0;
        do begin
            @(negedge clock);
            act.lat++;
            if (!out_valid && in_ready) busy++;
        end while (!out_valid && act.lat < 80);
        check("busy_ready", busy, 0);
        act.r = result;
        act.h = hi;
        act.l = lo;
        act.z = zero;
        act.v = overflow;
        act.il = illegal;
        out_ready = 1'b1;
        @(posedge clock);
        #1;
        out_ready = 1'b0;
    endtask

    function automatic vec_t mk(input logic [3:0] o, input logic [31:0] a,
                                input logic [31:0] b, input logic [4:0] s,
                                input logic [31:0] r, input logic v,
                                input logic z, input logic il, input int lat,
                                input logic hl, input logic [31:0] h,
                                input logic [31:0] l);
        vec_t x;
        x.o = o; x.a = a; x.b = b; x.s = s;
        x.r = r; x.v = v; x.z = z; x.il = il; x.lat = lat;
        x.hl = hl; x.h = h; x.l = l;
        return x;
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'h0;
            1: return 32'h1;
            2: return 32'hFFFFFFFF;
            3: return 32'h80000000;
            4: return 32'h7FFFFFFF;
            default: return $urandom;
        endcase
    endfunction

    res_t act;
    res_t e;

    initial begin
        reset = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        op = 4'h0;
        rs = 32'd0;
        rt = 32'd0;
        shamt = 5'd0;
        m_hi = 32'd0;
        m_lo = 32'd0;
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b0;
        @(negedge clock);
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_result", result, 0);
        check("rst_hi", hi, 0);
        check("rst_lo", lo, 0);
        check("rst_zero", zero, 0);
        check("rst_overflow", overflow, 0);
        check("rst_illegal", illegal, 0);

        tbl.push_back(mk(4'h1, 32'h7FFFFFFF, 32'h1, 0, 32'h80000000, 1, 0, 0, 1, 0, 0, 0));
        tbl.push_back(mk(4'h9, 32'h0, 32'hF0000000, 4, 32'hFF000000, 0, 0, 0, 1, 0, 0, 0));
        tbl.push_back(mk(4'h8, 32'h0, 32'hF0000000, 4, 32'h0F000000, 0, 0, 0, 1, 0, 0, 0));
        tbl.push_back(mk(4'h2, 32'h80000000, 32'h1, 0, 32'h7FFFFFFF, 1, 0, 0, 1, 0, 0, 0));
        tbl.push_back(mk(4'hA, 32'hFFFFFFFF, 32'h1, 0, 32'h0, 0, 1, 0, 1, 0, 0, 0));
        tbl.push_back(mk(4'hB, 32'h0, 32'h1, 0, 32'hFFFFFFFF, 0, 0, 0, 1, 0, 0, 0));
        tbl.push_back(mk(4'h6, 32'hFFFFFFFF, 32'h1, 0, 32'h1, 0, 0, 0, 1, 0, 0, 0));
        tbl.push_back(mk(4'h6, 32'h1, 32'hFFFFFFFF, 0, 32'h0, 0, 1, 0, 1, 0, 0, 0));
        tbl.push_back(mk(4'h5, 32'h0, 32'h0, 0, 32'hFFFFFFFF, 0, 0, 0, 1, 0, 0, 0));
        tbl.push_back(mk(4'h3, 32'hF0F01234, 32'hFF00FF00, 0, 32'hF0001200, 0, 0, 0, 1, 0, 0, 0));
        tbl.push_back(mk(4'h4, 32'h0F000000, 32'h000000F0, 0, 32'h0F0000F0, 0, 0, 0, 1, 0, 0, 0));
        tbl.push_back(mk(4'h7, 32'h0, 32'h1, 31, 32'h80000000, 0, 0, 0, 1, 0, 0, 0));
        tbl.push_back(mk(4'h0, 32'h1234, 32'h5678, 0, 32'h0, 0, 1, 0, 1, 0, 0, 0));
        tbl.push_back(mk(4'hC, 32'hFFFFFFFD, 32'h7, 0, 32'hFFFFFFEB, 0, 0, 0, 33, 1, 32'hFFFFFFFF, 32'hFFFFFFEB));
        tbl.push_back(mk(4'h1, 32'h1, 32'h1, 0, 32'h2, 0, 0, 0, 1, 1, 32'hFFFFFFFF, 32'hFFFFFFEB));
        tbl.push_back(mk(4'hD, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 32'h1, 0, 0, 0, 33, 1, 32'hFFFFFFFE, 32'h1));
        tbl.push_back(mk(4'hC, 32'h80000000, 32'h80000000, 0, 32'h0, 0, 1, 0, 33, 1, 32'h40000000, 32'h0));
`ifdef ALU_DIV_EN
        tbl.push_back(mk(4'hE, 32'hFFFFFFF9, 32'h2, 0, 32'hFFFFFFFD, 0, 0, 0, 33, 1, 32'hFFFFFFFF, 32'hFFFFFFFD));
        tbl.push_back(mk(4'hE, 32'h1234, 32'h0, 0, 32'hFFFFFFFF, 0, 0, 0, 33, 1, 32'h1234, 32'hFFFFFFFF));
        tbl.push_back(mk(4'hF, 32'h7, 32'h0, 0, 32'hFFFFFFFF, 0, 0, 0, 33, 1, 32'h7, 32'hFFFFFFFF));
`else
        tbl.push_back(mk(4'hE, 32'hFFFFFFF9, 32'h2, 0, 32'h0, 0, 1, 1, 1, 1, 32'h40000000, 32'h0));
        tbl.push_back(mk(4'hF, 32'h7, 32'h0, 0, 32'h0, 0, 1, 1, 1, 1, 32'h40000000, 32'h0));
`endif
        tbl.push_back(mk(4'h1, 32'h0, 32'h0, 0, 32'h0, 0, 1, 0, 1, 0, 0, 0));
        tbl.push_back(mk(4'h1, 32'h80000000, 32'h80000000, 0, 32'h0, 1, 1, 0, 1, 0, 0, 0));

        foreach (tbl[i]) begin
            e = model(tbl[i].o, tbl[i].a, tbl[i].b, tbl[i].s);
            apply(tbl[i].o, tbl[i].a, tbl[i].b, tbl[i].s, act);
            check($sformatf("tbl%0d_result", i), act.r, tbl[i].r);
            check($sformatf("tbl%0d_overflow", i), act.v, tbl[i].v);
            check($sformatf("tbl%0d_zero", i), act.z, tbl[i].z);
            check($sformatf("tbl%0d_illegal", i), act.il, tbl[i].il);
            check($sformatf("tbl%0d_latency", i), act.lat, tbl[i].lat);
            if (tbl[i].hl) begin
                check($sformatf("tbl%0d_hi", i), act.h, tbl[i].h);
                check($sformatf("tbl%0d_lo", i), act.l, tbl[i].l);
            end
            check($sformatf("tbl%0d_model_hi", i), act.h, e.h);
            check($sformatf("tbl%0d_model_lo", i), act.l, e.l);
        end

        // Result held under backpressure; a second request waits for IDLE.
        @(negedge clock);
        in_valid = 1'b1;
        op = 4'hB;
        rs = 32'd5;
        rt = 32'd5;
        @(posedge clock);
        #1;
        op = 4'h1;
        rs = 32'd1;
        rt = 32'd1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clock);
            check("hold_valid", out_valid, 1);
            check("hold_ready", in_ready, 0);
            check("hold_result", result, 0);
            check("hold_zero", zero, 1);
        end
        out_ready = 1'b1;
        @(posedge clock);
        #1;
        out_ready = 1'b0;
        @(negedge clock);
        check("post_hs_ready", in_ready, 1);
        check("post_hs_valid", out_valid, 0);
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        @(negedge clock);
        check("queued_valid", out_valid, 1);
        check("queued_result", result, 2);
        out_ready = 1'b1;
        @(posedge clock);
        #1;
        out_ready = 1'b0;

        // Reset in the middle of a MULTU aborts it.
        @(negedge clock);
        in_valid = 1'b1;
        op = 4'hD;
        rs = 32'h12345678;
        rt = 32'h9ABCDEF0;
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clock);
        #1;
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        m_hi = 32'd0;
        m_lo = 32'd0;
        @(negedge clock);
        check("abort_ready", in_ready, 1);
        check("abort_valid", out_valid, 0);
        check("abort_hi", hi, 0);
        check("abort_lo", lo, 0);
        repeat (40) begin
            @(negedge clock);
            if (out_valid) break;
        end
        check("abort_no_result", out_valid, 0);
        e = model(4'h1, 32'd2, 32'd3, 5'd0);
        apply(4'h1, 32'd2, 32'd3, 5'd0, act);
        check("abort_add_result", act.r, 5);

        for (int n = 0; n < 300; n++) begin
            logic [3:0]  ro;
            logic [31:0] ra;
            logic [31:0] rb;
            logic [4:0]  rsh;
            ro = 4'($urandom_range(0, 15));
            ra = pick();
            rb = pick();
            rsh = 5'($urandom);
            e = model(ro, ra, rb, rsh);
            apply(ro, ra, rb, rsh, act);
            check($sformatf("rnd%0d_op%h_result", n, ro), act.r, e.r);
            check($sformatf("rnd%0d_op%h_hi", n, ro), act.h, e.h);
            check($sformatf("rnd%0d_op%h_lo", n, ro), act.l, e.l);
            check($sformatf("rnd%0d_op%h_zero", n, ro), act.z, e.z);
            check($sformatf("rnd%0d_op%h_overflow", n, ro), act.v, e.v);
            check($sformatf("rnd%0d_op%h_illegal", n, ro), act.il, e.il);
            check($sformatf("rnd%0d_op%h_latency", n, ro), act.lat, e.lat);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
